// File: rtl/gate_op_scheduler.sv
// gate_op_scheduler: round-robin arbiter sharing one WIDTH-bit bitwise gate unit among NREQ requesters.
// Latency: grant and capture in the IDLE cycle, registered result valid from the next cycle; at most one result per 2 cycles.
// Backpressure: the result is held in RESP until rsp_ready; no requester is granted while a result is pending.
// Optional feature: define GATE_SCHED_STATS_EN to add the saturating 16-bit stat_count output.
module gate_op_scheduler #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [3*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_err
`ifdef GATE_SCHED_STATS_EN
    ,
    output logic [15:0]           stat_count
`endif
);

    // Opcode encoding of the shared gate unit.
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_ptr;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic [IDW-1:0]   r_rsp_id;
    logic             r_rsp_err;

    int               w_cand;
    logic             w_gnt_any;
    logic [IDW-1:0]   w_gnt_idx;
    logic             w_grant;
    logic [IDW-1:0]   w_ptr_next;
    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_res;
    logic             w_err;

    // Rotating search: first asserted req_valid at or after r_ptr, wrapping modulo NREQ.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_cand    = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = (int'(r_ptr) + k) % NREQ;
            if (!w_gnt_any && req_valid[IDW'(w_cand)]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = IDW'(w_cand);
            end
        end
    end

    // A transfer only happens in IDLE and never while reset is held.
    assign w_grant    = (r_state == ST_IDLE) && w_gnt_any && !rst;
    assign req_ready  = w_grant ? (NREQ'(1) << w_gnt_idx) : '0;
    assign w_ptr_next = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    // Operand mux from the winning requester's slices.
    assign w_op = req_op[3*w_gnt_idx +: 3];
    assign w_a  = req_a[WIDTH*w_gnt_idx +: WIDTH];
    assign w_b  = req_b[WIDTH*w_gnt_idx +: WIDTH];

    // Shared bitwise gate unit; the reserved opcode yields zero data and flags an error.
    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        case (w_op)
            OP_AND:  w_res = w_a & w_b;
            OP_OR:   w_res = w_a | w_b;
            OP_NOT:  w_res = ~w_a;
            OP_NAND: w_res = ~(w_a & w_b);
            OP_NOR:  w_res = ~(w_a | w_b);
            OP_XOR:  w_res = w_a ^ w_b;
            OP_XNOR: w_res = ~(w_a ^ w_b);
            default: begin
                w_res = '0;
                w_err = 1'b1;
            end
        endcase
    end

    // Scheduler FSM: capture the granted result in IDLE, hold it in RESP until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_rsp_data  <= w_res;
                        r_rsp_err   <= w_err;
                        r_rsp_id    <= w_gnt_idx;
                        r_ptr       <= w_ptr_next;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign rsp_err   = r_rsp_err;

`ifdef GATE_SCHED_STATS_EN
    logic [15:0] r_stat_count;

    // Completed-response counter, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_count <= '0;
        end else if (r_rsp_valid && rsp_ready && (r_stat_count != 16'hFFFF)) begin
            r_stat_count <= r_stat_count + 16'd1;
        end
    end

    assign stat_count = r_stat_count;
`else
    // Statistics counter not built.
`endif

endmodule
